// File: rtl/store_buf_pkg.sv
// Shared types and lane-alignment helper for the store alignment buffer.
// Holds size encodings, the buffer entry layout and the alignment function.
package store_buf_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // Widest supported bus; narrower configurations use the low slices.
    localparam int MAX_LANES  = 8;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_ADDR_W = 64;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_LANES-1:0]  be;
    } entry_t;

    typedef struct packed {
        logic [MAX_LANES-1:0]  be;
        logic [MAX_DATA_W-1:0] wdata;
        logic                  err;
    } align_t;

    // Little-endian lane placement; a rejected store yields be=0, wdata=0.
    function automatic align_t lane_align(
        input logic [1:0]  size,
        input logic [2:0]  offset,
        input logic [31:0] data
    );
        align_t      r;
        logic [7:0]  be;
        logic [31:0] d;
        r  = '0;
        be = '0;
        d  = '0;
        unique case (1'b1)
            (size == SZ_WORD): begin
                be    = 8'h0F;
                d     = data;
                r.err = |offset[1:0];
            end
            (size == SZ_HALF): begin
                be    = 8'h03;
                d     = {16'h0, data[15:0]};
                r.err = offset[0];
            end
            (size == SZ_BYTE): begin
                be    = 8'h01;
                d     = {24'h0, data[7:0]};
                r.err = 1'b0;
            end
            default: r.err = 1'b1;
        endcase
        if (!r.err) begin
            r.be    = be << offset;
            r.wdata = {32'h0, d} << {offset, 3'b000};
        end
        return r;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store alignment: lane shift, byte enables, misalignment check.
// Ports: size_i, offset_i, data_i in; be_o, wdata_o, err_o out.
module store_lane_align
    import store_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(LANES)
) (
    input  logic [1:0]        size_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [31:0]       data_i,
    output logic [LANES-1:0]  be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              err_o
);

    align_t res;
    logic   spill;

    assign res = lane_align(size_i, 3'(offset_i), data_i);

    // A store that would reach past the bus is rejected rather than clipped.
    if (DATA_W == 32) begin : g_narrow
        assign spill   = |{res.be[7:4], res.wdata[63:32]};
        assign be_o    = res.be[3:0];
        assign wdata_o = res.wdata[31:0];
    end else begin : g_wide
        assign spill   = 1'b0;
        assign be_o    = res.be;
        assign wdata_o = res.wdata;
    end

    assign err_o = res.err | spill;

endmodule

// File: rtl/store_align_buffer.sv
// Store alignment and write buffer between MEM stage and data memory.
// Ports: st_* request side (valid/ready, addr, data, size, err pulse),
//        mem_* drain side (valid/ready, addr, wdata, be), count, empty.
// Optional: STORE_BUF_MERGE_EN merges same-word stores into the tail entry.
module store_align_buffer
    import store_buf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_size,
    output logic                     st_err,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/8-1:0]      mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [LANES-1:0]  be_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [LANES-1:0]  lane_be;
    logic [DATA_W-1:0] lane_wdata;
    logic              lane_err;
    logic [ADDR_W-1:0] st_line;
    logic              full, push, pop, ok, merge, alloc;

    store_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size_i   (st_size),
        .offset_i (st_addr[OFF_W-1:0]),
        .data_i   (st_data),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .err_o    (lane_err)
    );

    assign st_line = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign st_ready = !full;
    assign st_err  = err_q;

    assign push = st_valid && st_ready;
    assign pop  = mem_valid && mem_ready;
    assign ok   = push && !lane_err;

`ifdef STORE_BUF_MERGE_EN
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] merge_data;

    // count>=2 keeps the tail distinct from the head being presented.
    assign tail  = wr_ptr_q - PTR_W'(1);
    assign merge = ok && (count_q >= CNT_W'(2))
                   && (st_line == addr_q[tail]);

    always_comb begin
        merge_data = data_q[tail];
        for (int l = 0; l < LANES; l++) begin
            if (lane_be[l]) merge_data[l*8 +: 8] = lane_wdata[l*8 +: 8];
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign alloc = ok && !merge;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = push && lane_err;
        if (alloc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({alloc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else if (alloc) begin
            addr_q[wr_ptr_q] <= st_line;
            data_q[wr_ptr_q] <= lane_wdata;
            be_q[wr_ptr_q]   <= lane_be;
        end
`ifdef STORE_BUF_MERGE_EN
        else if (merge) begin
            data_q[tail] <= merge_data;
            be_q[tail]   <= be_q[tail] | lane_be;
        end
`endif
    end

    // Head entry is held in storage, so outputs are stable under backpressure.
    assign mem_valid = !empty;
    assign mem_addr  = mem_valid ? addr_q[rd_ptr_q] : '0;
    assign mem_wdata = mem_valid ? data_q[rd_ptr_q] : '0;
    assign mem_be    = mem_valid ? be_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer (DATA_W=32, DEPTH=4).
// Directed vector table plus full, wrap, async-reset and merge sequences.
module tb_store_align_buffer;

    logic        Clk;
    logic        Reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;
    logic        empty;

    int pass_cnt;
    int total_cnt;

    store_align_buffer #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (4)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_err    (st_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count),
        .empty     (empty)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        Reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_size   = 2'd0;
        mem_ready = 1'b0;

        vecs[0] = '{32'h1003, 32'hAB,       2'd2, 1'b0,
                    32'h1000, 32'hAB000000, 4'b1000};
        vecs[1] = '{32'h2002, 32'h1234CDEF, 2'd1, 1'b0,
                    32'h2000, 32'hCDEF0000, 4'b1100};
        vecs[2] = '{32'h2001, 32'h1234CDEF, 2'd1, 1'b1,
                    32'h0,    32'h0,        4'b0000};
        vecs[3] = '{32'h4000, 32'hDEADBEEF, 2'd0, 1'b0,
                    32'h4000, 32'hDEADBEEF, 4'b1111};
        vecs[4] = '{32'h4002, 32'hDEADBEEF, 2'd0, 1'b1,
                    32'h0,    32'h0,        4'b0000};
        vecs[5] = '{32'h5000, 32'h1,        2'd3, 1'b1,
                    32'h0,    32'h0,        4'b0000};
        vecs[6] = '{32'h5000, 32'h123456CD, 2'd2, 1'b0,
                    32'h5000, 32'h000000CD, 4'b0001};
        vecs[7] = '{32'h6000, 32'hFFFF8001, 2'd1, 1'b0,
                    32'h6000, 32'h00008001, 4'b0011};
        vecs[8] = '{32'h7001, 32'h55,       2'd2, 1'b0,
                    32'h7000, 32'h00005500, 4'b0010};

        // Reset state
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_ready", 64'(st_ready), 64'd1);
        check("rst_mvalid", 64'(mem_valid), 64'd0);
        check("rst_maddr", 64'(mem_addr), 64'd0);
        check("rst_mwdata", 64'(mem_wdata), 64'd0);
        check("rst_mbe", 64'(mem_be), 64'd0);
        check("rst_err", 64'(st_err), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Vector table: one store per cycle, drained every cycle
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            st_addr  = vecs[i].addr;
            st_data  = vecs[i].data;
            st_size  = vecs[i].size;
            st_valid = 1'b1;
            tick();
            st_valid = 1'b0;
            check($sformatf("v%0d_err", i), 64'(st_err),
                  64'(vecs[i].err));
            check($sformatf("v%0d_count", i), 64'(count),
                  vecs[i].err ? 64'd0 : 64'd1);
            check($sformatf("v%0d_mvalid", i), 64'(mem_valid),
                  vecs[i].err ? 64'd0 : 64'd1);
            check($sformatf("v%0d_addr", i), 64'(mem_addr),
                  64'(vecs[i].e_addr));
            check($sformatf("v%0d_wdata", i), 64'(mem_wdata),
                  64'(vecs[i].e_wdata));
            check($sformatf("v%0d_be", i), 64'(mem_be),
                  64'(vecs[i].e_be));
        end
        tick();
        check("tbl_empty", 64'(empty), 64'd1);
        check("tbl_err_low", 64'(st_err), 64'd0);

        // Fill to DEPTH under backpressure, 5th request held
        mem_ready = 1'b0;
        st_size   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            st_addr  = 32'h100 * (i + 1);
            st_data  = 32'(i);
            st_valid = 1'b1;
            tick();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(st_ready), 64'd0);
        check("full_head", 64'(mem_addr), 64'h100);
        st_addr = 32'h500;
        st_data = 32'h5;
        tick();
        tick();
        check("full_held", 64'(count), 64'd4);
        check("full_stable", 64'(mem_addr), 64'h100);
        mem_ready = 1'b1;
        tick();
        check("full_pop1", 64'(count), 64'd3);
        check("full_ready1", 64'(st_ready), 64'd1);
        check("full_head1", 64'(mem_addr), 64'h200);
        tick();
        st_valid = 1'b0;
        check("full_acc5", 64'(count), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("full_order%0d", k), 64'(mem_addr),
                  64'(32'h300 + 32'h100 * k));
            tick();
        end
        check("full_drained", 64'(empty), 64'd1);

        // Push and pop together at count=2 across pointer wrap
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_addr  = 32'hA000 + 32'(4 * i);
            st_data  = 32'(i);
            st_valid = 1'b1;
            exp_q.push_back(st_addr);
            tick();
        end
        check("wrap_pre", 64'(count), 64'd2);
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            st_addr = 32'hA008 + 32'(4 * k);
            st_data = 32'(k + 2);
            check($sformatf("wrap_head%0d", k), 64'(mem_addr),
                  64'(exp_q[0]));
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(st_addr);
            check($sformatf("wrap_cnt%0d", k), 64'(count),
                  64'(exp_q.size()));
        end
        st_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wrap_tail%0d", k), 64'(mem_addr),
                  64'(exp_q[0]));
            tick();
            void'(exp_q.pop_front());
        end
        check("wrap_empty", 64'(empty), 64'd1);

        // Async reset while holding three entries
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_addr  = 32'hB000 + 32'(4 * i);
            st_valid = 1'b1;
            tick();
        end
        st_valid = 1'b0;
        check("ar_pre", 64'(count), 64'd3);
        #2;
        Reset_n = 1'b0;
        #1;
        check("ar_mvalid", 64'(mem_valid), 64'd0);
        check("ar_count", 64'(count), 64'd0);
        check("ar_empty", 64'(empty), 64'd1);
        check("ar_ready", 64'(st_ready), 64'd1);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Same-word stores: merged with the feature, separate without
        mem_ready = 1'b0;
        st_valid  = 1'b1;
        st_addr   = 32'h3000;
        st_data   = 32'hCAFEF00D;
        st_size   = 2'd0;
        tick();
        st_addr = 32'h3004;
        st_data = 32'h11;
        st_size = 2'd2;
        tick();
        st_addr = 32'h3005;
        st_data = 32'h22;
        tick();
        st_valid = 1'b0;
`ifdef STORE_BUF_MERGE_EN
        check("mg_count", 64'(count), 64'd2);
`else
        check("mg_count", 64'(count), 64'd3);
`endif
        check("mg_head", 64'(mem_wdata), 64'hCAFEF00D);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("mg_addr", 64'(mem_addr), 64'h3004);
`ifdef STORE_BUF_MERGE_EN
        check("mg_be", 64'(mem_be), 64'b0011);
        check("mg_wdata", 64'(mem_wdata), 64'h00002211);
`else
        check("mg_be", 64'(mem_be), 64'b0001);
        check("mg_wdata", 64'(mem_wdata), 64'h00000011);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
